// File: rtl/max7219_frame_tx.sv
// Serialises a latched 64*N_DEV-bit frame to a MAX7219 daisy chain, one row per LOAD pulse (optional init words under INIT_SEQ_EN).
// Latency: busy the cycle after an accepted start; frame takes 8*T cycles (13*T with init), T = CLK_DIV*(2+32*N_DEV).
// Backpressure: start is ignored while busy; a new start is taken in the cycle done pulses.
module max7219_frame_tx #(
    parameter int N_DEV   = 2,
    parameter int CLK_DIV = 4
`ifdef INIT_SEQ_EN
    ,
    parameter logic [3:0] INTENSITY = 4'h8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [64*N_DEV-1:0]  frame,
    output logic                 busy,
    output logic                 done,
    output logic                 ser_clk,
    output logic                 ser_din,
    output logic                 ser_load
);
    localparam int NBITS = 16 * N_DEV;
    localparam int BW    = $clog2(NBITS);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW    = 64 * N_DEV;
    localparam int FIW   = $clog2(FW);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [2:0]    row_q, row_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          busy_q, done_q, done_d, ser_clk_q, ser_din_q, ser_load_q;
    logic          div_end, last_txn, in_txn_d;
    logic [BW-1:0] dev_d;
    logic [FIW-1:0] fidx_d;
    logic [7:0]    byte_d;
    logic [15:0]   word_d;
`ifdef INIT_SEQ_EN
    logic          init_pending_q, init_pending_d;
    logic          in_init_q, in_init_d;
    logic [2:0]    init_idx_q, init_idx_d;
`endif

    assign div_end = (div_q == DW'(CLK_DIV - 1));
`ifdef INIT_SEQ_EN
    assign last_txn = !in_init_q && (row_q == 3'd7);
`else
    assign last_txn = (row_q == 3'd7);
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        row_d   = row_q;
        frame_d = frame_q;
        done_d  = 1'b0;
`ifdef INIT_SEQ_EN
        init_pending_d = init_pending_q;
        in_init_d      = in_init_q;
        init_idx_d     = init_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d = frame;
                    state_d = S_SETUP;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    row_d   = '0;
`ifdef INIT_SEQ_EN
                    in_init_d      = init_pending_q;
                    init_idx_d     = '0;
                    init_pending_d = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_end) begin
                    div_d   = '0;
                    phase_d = !phase_q;
                    // a bit ends on the falling edge of its high phase
                    if (phase_q) begin
                        if (bit_q == BW'(NBITS - 1)) begin
                            bit_d   = '0;
                            state_d = S_LATCH;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                if (div_end) begin
                    div_d = '0;
                    if (last_txn) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
`ifdef INIT_SEQ_EN
                        if (in_init_q) begin
                            if (init_idx_q == 3'd4) begin
                                in_init_d  = 1'b0;
                                init_idx_d = '0;
                            end else begin
                                init_idx_d = init_idx_q + 3'd1;
                            end
                        end else begin
                            row_d = row_q + 3'd1;
                        end
`else
                        row_d = row_q + 3'd1;
`endif
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    // Word for the next cycle; devices go out highest index first.
    always_comb begin
        dev_d  = BW'(N_DEV - 1) - (bit_d >> 4);
        fidx_d = FIW'({dev_d, row_d, 3'b000});
        byte_d = frame_d[fidx_d +: 8];
        word_d = {4'h0, {1'b0, row_d} + 4'd1, byte_d};
`ifdef INIT_SEQ_EN
        if (in_init_d) begin
            case (init_idx_d)
                3'd0:    word_d = 16'h0C01;
                3'd1:    word_d = 16'h0B07;
                3'd2:    word_d = 16'h0900;
                3'd3:    word_d = {8'h0A, 4'h0, INTENSITY};
                default: word_d = 16'h0F00;
            endcase
        end
`endif
    end

    assign in_txn_d = (state_d == S_SETUP) || (state_d == S_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            row_q      <= '0;
            frame_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ser_clk_q  <= 1'b0;
            ser_din_q  <= 1'b0;
            ser_load_q <= 1'b1;
`ifdef INIT_SEQ_EN
            init_pending_q <= 1'b1;
            in_init_q      <= 1'b0;
            init_idx_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            row_q      <= row_d;
            frame_q    <= frame_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            ser_clk_q  <= (state_d == S_SHIFT) && phase_d;
            ser_din_q  <= in_txn_d && word_d[~bit_d[3:0]];
            ser_load_q <= !in_txn_d;
`ifdef INIT_SEQ_EN
            init_pending_q <= init_pending_d;
            in_init_q      <= in_init_d;
            init_idx_q     <= init_idx_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ser_clk  = ser_clk_q;
    assign ser_din  = ser_din_q;
    assign ser_load = ser_load_q;
endmodule

// File: tb/tb_max7219_frame_tx.sv
// Directed bench for max7219_frame_tx with a two-device daisy-chain model on the serial pins.
module tb_max7219_frame_tx;
    localparam int N_DEV   = 2;
    localparam int CLK_DIV = 4;
    localparam int T       = CLK_DIV * (2 + 32 * N_DEV);
`ifdef INIT_SEQ_EN
    localparam int NINIT = 5;
`else
    localparam int NINIT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] frame = '0;
    logic         busy, done, ser_clk, ser_din, ser_load;

    max7219_frame_tx #(.N_DEV(N_DEV), .CLK_DIV(CLK_DIV)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame(frame),
        .busy(busy), .done(done), .ser_clk(ser_clk), .ser_din(ser_din), .ser_load(ser_load)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Device-chain model: 32-bit shift register, captured on each LOAD rising edge.
    logic [31:0] sh;
    int          nbits;
    logic        prev_clk = 1'b0, prev_load = 1'b1, prev_din = 1'b0;
    logic [31:0] words[$];
    int          bitcounts[$];
    int          busy_len[$];
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          din_viol = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sh = '0; nbits = 0; prev_clk = 1'b0; prev_load = 1'b1; prev_din = 1'b0; busy_cnt = 0;
        end else begin
            if (ser_clk && !prev_clk) begin
                sh = {sh[30:0], ser_din};
                nbits++;
            end
            if (ser_clk && prev_clk && (ser_din != prev_din)) din_viol++;
            if (ser_load && !prev_load) begin
                words.push_back(sh);
                bitcounts.push_back(nbits);
                nbits = 0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                busy_len.push_back(busy_cnt);
                busy_cnt = 0;
            end
            prev_clk = ser_clk; prev_load = ser_load; prev_din = ser_din;
        end
    end

    function automatic logic [15:0] exp_word(input logic [127:0] f, input int txn, input int ninit, input int d);
        int r;
        if (txn < ninit) begin
            case (txn)
                0: return 16'h0C01;
                1: return 16'h0B07;
                2: return 16'h0900;
                3: return 16'h0A08;
                default: return 16'h0F00;
            endcase
        end
        r = txn - ninit;
        return {4'h0, 4'(r + 1), f[(d * 8 + r) * 8 +: 8]};
    endfunction

    task automatic check_frame(input logic [127:0] f, input int ninit, input int base, input string tag);
        for (int i = 0; i < ninit + 8; i++) begin
            if (base + i < words.size()) begin
                chk($sformatf("%s_w%0d", tag, i), words[base + i], {exp_word(f, i, ninit, 1), exp_word(f, i, ninit, 0)});
                chk($sformatf("%s_bits%0d", tag, i), bitcounts[base + i], 16 * N_DEV);
            end
        end
    endtask

    task automatic clear_mon();
        words.delete(); bitcounts.delete(); busy_len.delete(); done_cnt = 0;
    endtask

    task automatic send(input logic [127:0] f);
        @(negedge clk); start = 1'b1; frame = f;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, seen, 1);
    endtask

    logic [127:0] f1, f2, f4, f5;

    initial begin
        for (int k = 0; k < 16; k++) f1[k * 8 +: 8] = 8'(k);
        f2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        f4 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_5A5AA5A5;
        f5 = 128'h8001_4002_2004_1008_0810_0420_0240_0180;

        // reset and idle
        repeat (3) @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load", ser_load, 1);
        chk("rst_clk", ser_clk, 0);
        chk("rst_din", ser_din, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (60) @(negedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_load", ser_load, 1);
        chk("idle_clk", ser_clk, 0);
        chk("idle_words", words.size(), 0);

        // first frame, byte k = k
        clear_mon();
        send(f1);
        #1 chk("t2_busy_on", busy, 1);
        wait_done(20000, "t2");
        chk("t2_busy_len", busy_len.size() > 0 ? busy_len[0] : 0, (NINIT + 8) * T);
        chk("t2_ntxn", words.size(), NINIT + 8);
        check_frame(f1, NINIT, 0, "t2");
        if (words.size() == NINIT + 8) begin
            chk("t2_row0_lit", words[NINIT], 32'h0108_0100);
            chk("t2_row7_lit", words[NINIT + 7], 32'h080F_0807);
        end
        @(negedge clk); #1;
        chk("t2_done_pulse", done, 0);
        chk("t2_done_cnt", done_cnt, 1);

        // restart attempt and frame change mid-frame
        clear_mon();
        send(f2);
        repeat (500) @(negedge clk);
        frame = ~f2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 chk("t3_busy_mid", busy, 1);
        wait_done(20000, "t3");
        chk("t3_busy_len", busy_len.size() > 0 ? busy_len[0] : 0, 8 * T);
        chk("t3_ntxn", words.size(), 8);
        check_frame(f2, 0, 0, "t3");
        repeat (5) @(negedge clk);
        chk("t3_done_cnt", done_cnt, 1);

        // reset during row 3 shift
        clear_mon();
        send(f4);
        for (int i = 0; i < 20000 && words.size() < NINIT + 3; i++) @(negedge clk);
        chk("t4_reached_row3", words.size(), NINIT + 3);
        repeat (40) @(negedge clk); #1;
        chk("t4_in_txn", ser_load, 0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_load", ser_load, 1);
        chk("t4_rst_clk", ser_clk, 0);
        chk("t4_rst_din", ser_din, 0);
        chk("t4_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk); #1;
        chk("t4_no_done", done_cnt, 0);
        clear_mon();
        send(f4);
        wait_done(20000, "t4");
        chk("t4_busy_len", busy_len.size() > 0 ? busy_len[0] : 0, (NINIT + 8) * T);
        chk("t4_ntxn", words.size(), NINIT + 8);
        check_frame(f4, NINIT, 0, "t4");

        // back-to-back with start held high
        clear_mon();
        @(negedge clk); frame = f5; start = 1'b1;
        wait_done(20000, "t6a");
        chk("t6_gap_busy", busy, 0);
        @(negedge clk); #1;
        chk("t6_restart_busy", busy, 1);
        start = 1'b0;
        wait_done(20000, "t6b");
        chk("t6_nframes", busy_len.size(), 2);
        if (busy_len.size() == 2) begin
            chk("t6_len0", busy_len[0], 8 * T);
            chk("t6_len1", busy_len[1], 8 * T);
        end
        chk("t6_ntxn", words.size(), 16);
        check_frame(f5, 0, 0, "t6a");
        check_frame(f5, 0, 8, "t6b");
        repeat (10) @(negedge clk); #1;
        chk("t6_idle_busy", busy, 0);

        chk("din_stable_high", din_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
